// File: rtl/seven_seg_scan_driver_pkg.sv
// Shared symbol codes and segment bit positions for the 7-segment display path.
// Segment vectors are {a,b,c,d,e,f,g} with a in bit 6.
package seven_seg_scan_driver_pkg;

  localparam logic [4:0] SYM_0     = 5'd0;
  localparam logic [4:0] SYM_1     = 5'd1;
  localparam logic [4:0] SYM_2     = 5'd2;
  localparam logic [4:0] SYM_3     = 5'd3;
  localparam logic [4:0] SYM_4     = 5'd4;
  localparam logic [4:0] SYM_5     = 5'd5;
  localparam logic [4:0] SYM_6     = 5'd6;
  localparam logic [4:0] SYM_7     = 5'd7;
  localparam logic [4:0] SYM_8     = 5'd8;
  localparam logic [4:0] SYM_9     = 5'd9;
  localparam logic [4:0] SYM_A     = 5'd10;
  localparam logic [4:0] SYM_B     = 5'd11;
  localparam logic [4:0] SYM_C     = 5'd12;
  localparam logic [4:0] SYM_D     = 5'd13;
  localparam logic [4:0] SYM_E     = 5'd14;
  localparam logic [4:0] SYM_F     = 5'd15;
  localparam logic [4:0] SYM_L     = 5'd16;
  localparam logic [4:0] SYM_N     = 5'd17;
  localparam logic [4:0] SYM_O     = 5'd18;
  localparam logic [4:0] SYM_P     = 5'd19;
  localparam logic [4:0] SYM_R     = 5'd20;
  localparam logic [4:0] SYM_U     = 5'd21;
  localparam logic [4:0] SYM_H     = 5'd22;
  localparam logic [4:0] SYM_DASH  = 5'd23;
  localparam logic [4:0] SYM_BLANK = 5'h1F;

  localparam int SEG_A = 6;
  localparam int SEG_B = 5;
  localparam int SEG_C = 4;
  localparam int SEG_D = 3;
  localparam int SEG_E = 2;
  localparam int SEG_F = 1;
  localparam int SEG_G = 0;

  localparam int NUM_DIGITS = 4;

endpackage

// File: rtl/seven_seg_decoder.sv
// Combinational symbol-code to active-high {a..g} segment decoder.
// Codes 24..31 decode to blank; shared by any display consumer.
module seven_seg_decoder
  import seven_seg_scan_driver_pkg::*;
(
  input  logic [4:0] code,
  output logic [6:0] seg
);

  always_comb begin
    seg = 7'h00;
    case (code)
      SYM_0:    seg = 7'h7E;
      SYM_1:    seg = 7'h30;
      SYM_2:    seg = 7'h6D;
      SYM_3:    seg = 7'h79;
      SYM_4:    seg = 7'h33;
      SYM_5:    seg = 7'h5B;
      SYM_6:    seg = 7'h5F;
      SYM_7:    seg = 7'h70;
      SYM_8:    seg = 7'h7F;
      SYM_9:    seg = 7'h7B;
      SYM_A:    seg = 7'h77;
      SYM_B:    seg = 7'h1F;
      SYM_C:    seg = 7'h4E;
      SYM_D:    seg = 7'h3D;
      SYM_E:    seg = 7'h4F;
      SYM_F:    seg = 7'h47;
      SYM_L:    seg = 7'h0E;
      SYM_N:    seg = 7'h15;
      SYM_O:    seg = 7'h1D;
      SYM_P:    seg = 7'h67;
      SYM_R:    seg = 7'h05;
      SYM_U:    seg = 7'h1C;
      SYM_H:    seg = 7'h37;
      SYM_DASH: seg = 7'h01;
      default:  seg = 7'h00;
    endcase
  end

endmodule

// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed 4-digit 7-segment scan driver with dead-time, blink and
// frame-synchronous content update (shadow applied only at frame boundary).
module seven_seg_scan_driver
  import seven_seg_scan_driver_pkg::*;
#(
  parameter int SCAN_DIV     = 50000,
  parameter int DEAD_CYCLES  = 500,
  parameter int BLINK_FRAMES = 100,
  parameter bit ACTIVE_LOW   = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [19:0] sym,
  input  logic [3:0]  dp_mask,
  input  logic [3:0]  blink_mask,
  output logic [3:0]  digit_en,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        frame_start
);

  localparam int SLOT_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int FRAME_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [SLOT_W-1:0]  slot_cnt;
  logic [1:0]         digit_idx;
  logic [FRAME_W-1:0] frame_cnt;
  logic               blink_phase;

  logic [19:0] shadow_sym, active_sym;
  logic [3:0]  shadow_dp, shadow_blink, active_dp, active_blink;
  logic        pending;

  logic slot_wrap, frame_wrap, frame_last;

  assign slot_wrap  = (slot_cnt == SLOT_W'(SCAN_DIV - 1));
  assign frame_wrap = slot_wrap && (digit_idx == 2'd3);
  assign frame_last = (frame_cnt == FRAME_W'(BLINK_FRAMES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_cnt    <= '0;
      digit_idx   <= 2'd0;
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
    end else begin
      if (slot_wrap) begin
        slot_cnt  <= '0;
        digit_idx <= digit_idx + 2'd1;
      end else begin
        slot_cnt <= slot_cnt + SLOT_W'(1);
      end
      if (frame_wrap) begin
        if (frame_last) begin
          frame_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          frame_cnt <= frame_cnt + FRAME_W'(1);
        end
      end
    end
  end

  // A load coinciding with the boundary lands in shadow only; active takes the older shadow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_sym   <= {NUM_DIGITS{SYM_BLANK}};
      shadow_dp    <= '0;
      shadow_blink <= '0;
      active_sym   <= {NUM_DIGITS{SYM_BLANK}};
      active_dp    <= '0;
      active_blink <= '0;
      pending      <= 1'b0;
    end else begin
      if (frame_wrap && pending) begin
        active_sym   <= shadow_sym;
        active_dp    <= shadow_dp;
        active_blink <= shadow_blink;
      end
      if (load) begin
        shadow_sym   <= sym;
        shadow_dp    <= dp_mask;
        shadow_blink <= blink_mask;
        pending      <= 1'b1;
      end else if (frame_wrap) begin
        pending <= 1'b0;
      end
    end
  end

  logic [4:0] cur_code;
  logic [6:0] dec_seg;
  logic       in_dead, blanked;
  logic [3:0] en_nxt;
  logic [6:0] seg_nxt;
  logic       dp_nxt, fs_nxt;

  assign cur_code = active_sym[5*digit_idx +: 5];

  seven_seg_decoder u_decoder (
    .code (cur_code),
    .seg  (dec_seg)
  );

  always_comb begin
    en_nxt  = 4'h0;
    seg_nxt = 7'h00;
    dp_nxt  = 1'b0;
    in_dead = (slot_cnt < SLOT_W'(DEAD_CYCLES));
    blanked = blink_phase && active_blink[digit_idx];
    fs_nxt  = (slot_cnt == '0) && (digit_idx == 2'd0);
    if (!in_dead) begin
      en_nxt[digit_idx] = 1'b1;
      if (!blanked) begin
        seg_nxt = dec_seg;
        dp_nxt  = active_dp[digit_idx];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit_en    <= {4{ACTIVE_LOW}};
      seg         <= {7{ACTIVE_LOW}};
      dp          <= ACTIVE_LOW;
      frame_start <= 1'b0;
    end else begin
      digit_en    <= en_nxt ^ {4{ACTIVE_LOW}};
      seg         <= seg_nxt ^ {7{ACTIVE_LOW}};
      dp          <= dp_nxt ^ ACTIVE_LOW;
      frame_start <= fs_nxt;
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Bench for seven_seg_scan_driver: cycle-count based reference model plus
// directed and randomized loads, with literal per-frame captures pinning the model.
module tb_seven_seg_scan_driver;
  import seven_seg_scan_driver_pkg::*;

  localparam int SD = 8;
  localparam int DC = 2;
  localparam int BF = 2;
  localparam int FR = 4 * SD;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic [19:0] sym = '0;
  logic [3:0]  dp_mask = '0;
  logic [3:0]  blink_mask = '0;
  logic [3:0]  digit_en;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_start;

  int errors = 0;
  int checks = 0;

  seven_seg_scan_driver #(
    .SCAN_DIV(SD), .DEAD_CYCLES(DC), .BLINK_FRAMES(BF), .ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .sym(sym), .dp_mask(dp_mask),
    .blink_mask(blink_mask), .digit_en(digit_en), .seg(seg), .dp(dp),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Active-high segment table straight from the symbol list.
  logic [6:0] seg_tab [32] = '{
    7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
    7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47,
    7'h0E, 7'h15, 7'h1D, 7'h67, 7'h05, 7'h1C, 7'h37, 7'h01,
    7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00};

  // Model: the k-th clock edge after reset release shows position k of the
  // scan; frame F displays the last load sampled before the boundary edge F*FR-1.
  int         ecnt = 0;
  int         m_slot, m_idx, m_frm;
  bit         m_off;
  logic [19:0] lat_sym = '1, cur_sym = '1;
  logic [3:0]  lat_dp = '0, lat_bl = '0, cur_dp = '0, cur_bl = '0;
  logic [3:0]  exp_en = 4'hF;
  logic [6:0]  exp_seg = 7'h7F;
  logic        exp_dp = 1'b1;
  logic        exp_fs = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ecnt = 0;
      lat_sym = '1; cur_sym = '1;
      lat_dp = '0; lat_bl = '0; cur_dp = '0; cur_bl = '0;
      exp_en = 4'hF; exp_seg = 7'h7F; exp_dp = 1'b1; exp_fs = 1'b0;
    end else begin
      m_slot = ecnt % SD;
      m_idx  = (ecnt / SD) % 4;
      m_frm  = ecnt / FR;
      exp_fs = ((ecnt % FR) == 0);
      if (m_slot < DC) begin
        exp_en = 4'hF; exp_seg = 7'h7F; exp_dp = 1'b1;
      end else begin
        exp_en  = 4'(~(4'b0001 << m_idx));
        m_off   = (((m_frm / BF) % 2) == 1) && cur_bl[m_idx];
        exp_seg = m_off ? 7'h7F : ~seg_tab[cur_sym[m_idx*5 +: 5]];
        exp_dp  = m_off ? 1'b1 : ~cur_dp[m_idx];
      end
      if ((ecnt % FR) == FR - 1) begin
        cur_sym = lat_sym; cur_dp = lat_dp; cur_bl = lat_bl;
      end
      if (load) begin
        lat_sym = sym; lat_dp = dp_mask; lat_bl = blink_mask;
      end
      ecnt++;
    end
  end

  always @(negedge clk) begin
    check("digit_en", 32'(digit_en), 32'(exp_en));
    check("seg", 32'(seg), 32'(exp_seg));
    check("dp", 32'(dp), 32'(exp_dp));
    check("frame_start", 32'(frame_start), 32'(exp_fs));
    check("onehot", 32'($countones(~digit_en) <= 1), 32'd1);
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_load(input logic [19:0] s, input logic [3:0] d, input logic [3:0] b);
    sym = s; dp_mask = d; blink_mask = b; load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic wait_fs();
    int n = 0;
    while (!frame_start && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("frame_start_seen", 32'(frame_start), 32'd1);
  endtask

  logic [6:0] cap_seg [4];
  logic       cap_dp  [4];
  int         cap_hit [4];

  task automatic capture_frame();
    wait_fs();
    for (int i = 0; i < 4; i++) begin
      cap_seg[i] = 7'h55; cap_dp[i] = 1'b0; cap_hit[i] = 0;
    end
    for (int c = 0; c < FR; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (digit_en == 4'(~(4'b0001 << i))) begin
          cap_seg[i] = seg; cap_dp[i] = dp; cap_hit[i]++;
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_pos(input int pos);
    int n = 0;
    while ((ecnt % FR) != pos && n < 2 * FR) begin
      @(negedge clk);
      n++;
    end
    check("wait_pos", 32'(ecnt % FR), 32'(pos));
  endtask

  int blanks;

  initial begin
    step(3);
    rst_n = 1'b1;

    // Blank scan after reset: every digit on for SD-DC cycles, all segments off.
    capture_frame();
    for (int i = 0; i < 4; i++) begin
      check("t1_hits", 32'(cap_hit[i]), 32'(SD - DC));
      check("t1_seg", 32'(cap_seg[i]), 32'h7F);
      check("t1_dp", 32'(cap_dp[i]), 32'd1);
    end

    step(8);
    do_load({SYM_3, SYM_2, SYM_1, SYM_0}, 4'b0010, 4'b0000);
    capture_frame();
    check("t2_d0", 32'(cap_seg[0]), 32'h01);
    check("t2_d1", 32'(cap_seg[1]), 32'h4F);
    check("t2_d1dp", 32'(cap_dp[1]), 32'd0);
    check("t2_d0dp", 32'(cap_dp[0]), 32'd1);
    check("t2_d2", 32'(cap_seg[2]), 32'h12);
    check("t2_d3", 32'(cap_seg[3]), 32'h06);

    step(5);
    do_load({4{SYM_E}}, 4'b0000, 4'b0000);
    step(5);
    do_load({4{SYM_L}}, 4'b0000, 4'b0000);
    capture_frame();
    check("t3_d0", 32'(cap_seg[0]), 32'h71);
    check("t3_d3", 32'(cap_seg[3]), 32'h71);

    step(3);
    do_load({4{SYM_H}}, 4'b0000, 4'b0000);
    wait_pos(FR - 1);
    do_load({4{SYM_8}}, 4'b1111, 4'b0000);
    capture_frame();
    check("t4_old", 32'(cap_seg[2]), 32'h48);
    check("t4_olddp", 32'(cap_dp[2]), 32'd1);
    capture_frame();
    check("t4_new", 32'(cap_seg[2]), 32'h00);
    check("t4_newdp", 32'(cap_dp[2]), 32'd0);

    do_load({SYM_A, SYM_C, SYM_F, SYM_5}, 4'b0000, 4'b0001);
    capture_frame();
    blanks = 0;
    for (int f = 0; f < 4; f++) begin
      capture_frame();
      if (cap_seg[0] == 7'h7F) blanks++;
      check("t5_d0hits", 32'(cap_hit[0]), 32'(SD - DC));
      check("t5_d1", 32'(cap_seg[1]), 32'h38);
    end
    check("t5_blank_frames", 32'(blanks), 32'd2);

    for (int r = 0; r < 12; r++) begin
      step($urandom_range(0, 40));
      do_load(20'($urandom), 4'($urandom), 4'($urandom));
    end
    step(3 * FR);

    wait_pos(2 * SD + 4);
    check("t6_pre_en", 32'(digit_en), 32'hB);
    #2 rst_n = 1'b0;
    #1;
    check("t6_async_en", 32'(digit_en), 32'hF);
    check("t6_async_seg", 32'(seg), 32'h7F);
    check("t6_async_dp", 32'(dp), 32'd1);
    step(2);
    rst_n = 1'b1;
    capture_frame();
    for (int i = 0; i < 4; i++) begin
      check("t6_hits", 32'(cap_hit[i]), 32'(SD - DC));
      check("t6_seg", 32'(cap_seg[i]), 32'h7F);
    end
    step(FR);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1, "timeout");
  end

endmodule
